// File: rtl/spi_shift_out.sv
// spi_shift_out: mode-0, MSB-first parallel-to-serial transmitter with an
// active-low chip select. A one-cycle START in IDLE latches D and runs one
// frame of SETUP, WIDTH SCLK high/low periods and a trailing HOLD. Every
// output is taken from a register that is loaded from the next-state value.
module spi_shift_out #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             CS_B,
  output logic             SCLK,
  output logic             MOSI
);

  localparam int BIT_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int PH_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              done_d;
  logic              phase_last;

  // The current state visit ends once CLKDIV cycles have elapsed.
  assign phase_last = (phase_q == PH_W'(CLKDIV - 1));

  // Next-state, counter and shift-register update.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    if (state_q != IDLE) begin
      phase_d = phase_last ? '0 : phase_q + PH_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SETUP;
          shreg_d = D;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (phase_last) state_d = HIGH;
      end
      HIGH: begin
        if (phase_last) begin
          if (bit_q < BIT_W'(WIDTH - 1)) begin
            // Entering LOW: present the next lower bit to the receiver.
            state_d = LOW;
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            state_d = HOLD;
          end
        end
      end
      LOW: begin
        if (phase_last) state_d = HIGH;
      end
      HOLD: begin
        if (phase_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs; reset abandons any frame.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      CS_B    <= 1'b1;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      CS_B    <= (state_d == IDLE);
      SCLK    <= (state_d == HIGH);
      BUSY    <= (state_d != IDLE);
      DONE    <= done_d;
      // MOSI keeps its last value while idle so it never follows stale data.
      if (state_d != IDLE) MOSI <= shreg_d[WIDTH-1];
    end
  end

  // Shift register holds data only; its content is qualified by state.
  always_ff @(posedge C) begin
    shreg_q <= shreg_d;
  end

endmodule
